// File: rtl/adder_share_arb.sv
// Round-robin / fixed-priority arbiter that sequences two requesters onto one shared
// WIDTH-bit adder: grant, operand capture, add, then a one-cycle DONE pulse.
module adder_share_arb #(
  parameter int WIDTH = 8,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             done_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic             win_s;
  logic             last_r;
  logic             gnt0_s;
  logic             gnt1_s;
  logic             done_s;
  logic             busy_s;
  logic [WIDTH-1:0] mux_a_s;
  logic [WIDTH-1:0] mux_b_s;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH:0]   sum_s;

  // Next state, arbitration winner and next-cycle values of the registered outputs.
  always_comb begin
    next_state_s = state_r;
    win_s        = sel;
    gnt0_s       = 1'b0;
    gnt1_s       = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          next_state_s = LOAD;
          if (req0 && req1) begin
            win_s = RR_EN ? ~last_r : 1'b0;
          end else begin
            win_s = req1;
          end
          gnt0_s = ~win_s;
          gnt1_s = win_s;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD:    next_state_s = EXEC;
      EXEC: begin
        next_state_s = RESP;
        done_s       = 1'b1;
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
    busy_s = (next_state_s != IDLE);
  end

  // Shared operand mux and adder.
  always_comb begin
    mux_a_s = sel ? a1 : a0;
    mux_b_s = sel ? b1 : b0;
    sum_s   = {1'b0, opa_r} + {1'b0, opb_r};
  end

  // State, operand and result registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      sel     <= 1'b0;
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      sum     <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      sel     <= win_s;
      gnt0    <= gnt0_s;
      gnt1    <= gnt1_s;
      done    <= done_s;
      busy    <= busy_s;
      if (state_r == LOAD) begin
        opa_r <= mux_a_s;
        opb_r <= mux_b_s;
      end
      // Result and round-robin history advance together so SUM/DONE_ID/LAST agree.
      if (state_r == EXEC) begin
        {cout, sum} <= sum_s;
        done_id     <= sel;
        last_r      <= sel;
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: a round-robin and a fixed-priority instance share the same
// stimulus; a transaction-level model predicts every output each cycle, plus literal checks.
module tb_adder_share_arb;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;

  logic [1:0] gnt0_o, gnt1_o, sel_o, cout_o, done_o, done_id_o, busy_o;
  logic [7:0] sum_o [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  adder_share_arb #(.WIDTH(8), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .sel(sel_o[0]),
    .sum(sum_o[0]), .cout(cout_o[0]), .done(done_o[0]),
    .done_id(done_id_o[0]), .busy(busy_o[0])
  );

  adder_share_arb #(.WIDTH(8), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .sel(sel_o[1]),
    .sum(sum_o[1]), .cout(cout_o[1]), .done(done_o[1]),
    .done_id(done_id_o[1]), .busy(busy_o[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction model, index 0 = round-robin instance, 1 = fixed priority.
  int         next_arb [2];
  int         gnt_cyc  [2];
  int         done_cyc [2];
  logic       m_last   [2];
  logic       gnt_id   [2];
  logic       p_cout   [2];
  logic       p_id     [2];
  logic [7:0] p_sum    [2];
  logic       e_sel    [2];
  logic       e_cout   [2];
  logic       e_id     [2];
  logic [7:0] e_sum    [2];

  always @(negedge clk) begin
    logic [14:0] exp_v;
    logic [14:0] act_v;
    logic        w;
    logic [8:0]  s;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        next_arb[d] = 0;
        gnt_cyc[d]  = -1;
        done_cyc[d] = -1;
        m_last[d]   = 1'b1;
        gnt_id[d]   = 1'b0;
        e_sel[d]    = 1'b0;
        e_cout[d]   = 1'b0;
        e_id[d]     = 1'b0;
        e_sum[d]    = 8'h00;
      end else begin
        if (cyc == gnt_cyc[d]) e_sel[d] = gnt_id[d];
        if (cyc == done_cyc[d]) begin
          e_sum[d]  = p_sum[d];
          e_cout[d] = p_cout[d];
          e_id[d]   = p_id[d];
        end
        exp_v = {(cyc == gnt_cyc[d]) && !gnt_id[d], (cyc == gnt_cyc[d]) && gnt_id[d],
                 e_sel[d], cyc == done_cyc[d], e_id[d],
                 (gnt_cyc[d] >= 0) && (cyc >= gnt_cyc[d]) && (cyc < next_arb[d]),
                 e_cout[d], e_sum[d]};
        act_v = {gnt0_o[d], gnt1_o[d], sel_o[d], done_o[d], done_id_o[d], busy_o[d],
                 cout_o[d], sum_o[d]};
        check((d == 0) ? "rr_cycle" : "fp_cycle", 32'(act_v), 32'(exp_v));
        if ((cyc >= next_arb[d]) && (req0 || req1)) begin
          if (req0 && req1) w = (d == 0) ? ~m_last[d] : 1'b0;
          else              w = req1;
          s = w ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
          m_last[d]   = w;
          gnt_id[d]   = w;
          p_sum[d]    = s[7:0];
          p_cout[d]   = s[8];
          p_id[d]     = w;
          gnt_cyc[d]  = cyc + 1;
          done_cyc[d] = cyc + 3;
          next_arb[d] = cyc + 4;
        end
      end
    end
  end

  initial begin
    int n_done;

    // Power-on reset.
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      check("reset_outs", 32'({gnt0_o[d], gnt1_o[d], sel_o[d], done_o[d], done_id_o[d],
                              busy_o[d], cout_o[d], sum_o[d]}), 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // Reset in EXEC discards the operation.
    a0 = 8'h10; b0 = 8'h20; req0 = 1'b1;
    step();
    step();
    req0 = 1'b0;
    rst  = 1'b1;
    #1;
    for (int d = 0; d < 2; d++)
      check("midexec_reset_outs", 32'({gnt0_o[d], gnt1_o[d], sel_o[d], done_o[d],
                                      done_id_o[d], busy_o[d], cout_o[d], sum_o[d]}), 32'h0);
    step();
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done_o[0] || done_o[1]) n_done++;
    end
    check("midexec_no_done", 32'(n_done), 32'd0);

    // Single request from requester 0.
    a0 = 8'h01; b0 = 8'hAA; req0 = 1'b1;
    step();
    check("single_gnt", 32'({gnt1_o[0], gnt0_o[0]}), 32'h1);
    step();
    req0 = 1'b0;
    step();
    check("single_done", 32'({done_o[0], done_id_o[0], cout_o[0], sum_o[0]}),
          32'({1'b1, 1'b0, 1'b0, 8'hAB}));
    step();
    step();

    // Carry out from requester 1.
    a1 = 8'hFF; b1 = 8'h01; req1 = 1'b1;
    step();
    check("carry_gnt", 32'({gnt1_o[0], gnt0_o[0]}), 32'h2);
    step();
    req1 = 1'b0;
    step();
    check("carry_done", 32'({done_o[0], done_id_o[0], cout_o[0], sel_o[0], sum_o[0]}),
          32'({1'b1, 1'b1, 1'b1, 1'b1, 8'h00}));
    step();
    step();

    // Both held: round-robin alternates, fixed priority always serves requester 0.
    a0 = 8'h55; b0 = 8'h0F; a1 = 8'h3C; b1 = 8'hA5;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i % 4 == 1) begin
        check("rr_gnt", 32'({gnt1_o[0], gnt0_o[0]}), ((i / 4) % 2 == 1) ? 32'h2 : 32'h1);
        check("fp_gnt", 32'({gnt1_o[1], gnt0_o[1]}), 32'h1);
      end
      if (i % 4 == 3) begin
        check("rr_sum", 32'({done_o[0], sum_o[0]}),
              ((i / 4) % 2 == 1) ? 32'({1'b1, 8'hE1}) : 32'({1'b1, 8'h64}));
        check("fp_sum", 32'({done_o[1], done_id_o[1], sum_o[1]}), 32'({1'b1, 1'b0, 8'h64}));
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    // Late request: requester 1 rises during requester 0's EXEC.
    a0 = 8'h21; b0 = 8'h12; a1 = 8'h07; b1 = 8'h08; req0 = 1'b1;
    step();
    step();
    req0 = 1'b0; req1 = 1'b1;
    step();
    check("late_done0", 32'({done_o[0], done_id_o[0], gnt1_o[0], sum_o[0]}),
          32'({1'b1, 1'b0, 1'b0, 8'h33}));
    step();
    check("late_idle", 32'({busy_o[0], gnt0_o[0], gnt1_o[0]}), 32'h0);
    step();
    check("late_gnt1", 32'({gnt1_o[1], gnt0_o[1], gnt1_o[0], gnt0_o[0]}), 32'hA);
    step();
    req1 = 1'b0;
    step();
    check("late_done1", 32'({done_o[0], done_id_o[0], cout_o[0], sum_o[0]}),
          32'({1'b1, 1'b1, 1'b0, 8'h0F}));
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
